fmul_arbiter: RTL and testbench



---
 rtl/fmul_arbiter_if.sv | 30 +++
 rtl/fmul_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fmul_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_arbiter_if.sv
// Requester-side bus of the shared FP multiplier arbiter.
// Operand and rounding fields are packed per requester, lowest index in the lowest bits.
interface fmul_arbiter_if #(
    parameter int precision = 32,
    parameter int NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*precision-1:0] req_a;
    logic [NUM_REQ*precision-1:0] req_b;
    logic [2*NUM_REQ-1:0]         req_rounding;

    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           resp_valid;
    logic [precision-1:0]         resp_result;
    logic                         resp_inv_op;
    logic                         resp_err;
    logic                         busy;

    // Requester side: drives requests, observes grant and responses.
    modport master (
        output req, req_a, req_b, req_rounding,
        input  grant, resp_valid, resp_result, resp_inv_op, resp_err, busy
    );

    // Arbiter side.
    modport slave (
        input  req, req_a, req_b, req_rounding,
        output grant, resp_valid, resp_result, resp_inv_op, resp_err, busy
    );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one FP multiplier among NUM_REQ requesters.
// Each operation is launched by releasing the multiplier's active-low reset.
module fmul_arbiter #(
    parameter int precision = 32,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fmul_arbiter_if.slave        bus,
    output logic                 mult_reset,
    output logic [precision-1:0] mult_a,
    output logic [precision-1:0] mult_b,
    output logic [1:0]           mult_rounding,
    input  logic [precision-1:0] mult_result,
    input  logic                 mult_done,
    input  logic                 mult_inv_op
);

    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT) + 1;
    localparam int EXP_W  = (precision == 64) ? 11 : ((precision == 16) ? 5 : 8);
    localparam int MANT_W = precision - 1 - EXP_W;

    // Quiet NaN returned when the multiplier never signals completion.
    localparam logic [precision-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_reg;
    logic [ID_W-1:0]       ptr_reg;
    logic [ID_W-1:0]       winner_reg;
    logic [ID_W-1:0]       winner_next;
    logic                  any_req;
    logic [CNT_W-1:0]      cnt_reg;

    logic                  mult_reset_reg;
    logic [precision-1:0]  mult_a_reg;
    logic [precision-1:0]  mult_b_reg;
    logic [1:0]            mult_rounding_reg;

    logic [NUM_REQ-1:0]    resp_valid_reg;
    logic [precision-1:0]  resp_result_reg;
    logic                  resp_inv_op_reg;
    logic                  resp_err_reg;
    logic                  busy_reg;

    logic [precision-1:0]  a_slice   [NUM_REQ];
    logic [precision-1:0]  b_slice   [NUM_REQ];
    logic [1:0]            rnd_slice [NUM_REQ];
    logic [ID_W-1:0]       cand_idx  [NUM_REQ];

    // cand_idx[k] is the requester examined k-th, starting just after the pointer.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign a_slice[gi]   = bus.req_a[gi*precision +: precision];
            assign b_slice[gi]   = bus.req_b[gi*precision +: precision];
            assign rnd_slice[gi] = bus.req_rounding[2*gi +: 2];
            assign cand_idx[gi]  = ID_W'((int'(ptr_reg) + 1 + gi) % NUM_REQ);
        end
    endgenerate

    // Descending scan so the earliest candidate in round-robin order wins.
    always_comb begin
        winner_next = '0;
        any_req     = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[cand_idx[k]]) begin
                winner_next = cand_idx[k];
                any_req     = 1'b1;
            end
        end
    end

    assign bus.grant = (reset && (state_reg == IDLE) && any_req)
                       ? (NUM_REQ'(1) << winner_next) : '0;

    assign bus.resp_valid  = resp_valid_reg;
    assign bus.resp_result = resp_result_reg;
    assign bus.resp_inv_op = resp_inv_op_reg;
    assign bus.resp_err    = resp_err_reg;
    assign bus.busy        = busy_reg;

    assign mult_reset    = mult_reset_reg;
    assign mult_a        = mult_a_reg;
    assign mult_b        = mult_b_reg;
    assign mult_rounding = mult_rounding_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= IDLE;
            ptr_reg           <= ID_W'(NUM_REQ - 1);
            winner_reg        <= '0;
            cnt_reg           <= '0;
            mult_reset_reg    <= 1'b0;
            mult_a_reg        <= '0;
            mult_b_reg        <= '0;
            mult_rounding_reg <= '0;
            resp_valid_reg    <= '0;
            resp_result_reg   <= '0;
            resp_inv_op_reg   <= 1'b0;
            resp_err_reg      <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    resp_valid_reg <= '0;
                    mult_reset_reg <= 1'b0;
                    if (any_req) begin
                        winner_reg        <= winner_next;
                        ptr_reg           <= winner_next;
                        mult_a_reg        <= a_slice[winner_next];
                        mult_b_reg        <= b_slice[winner_next];
                        mult_rounding_reg <= rnd_slice[winner_next];
                        mult_reset_reg    <= 1'b1;
                        cnt_reg           <= '0;
                        busy_reg          <= 1'b1;
                        state_reg         <= RUN;
                    end
                end

                // Completion takes priority over a timeout in the same cycle.
                RUN: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (mult_done) begin
                        resp_result_reg <= mult_result;
                        resp_inv_op_reg <= mult_inv_op;
                        resp_err_reg    <= 1'b0;
                        mult_reset_reg  <= 1'b0;
                        resp_valid_reg  <= NUM_REQ'(1) << winner_reg;
                        state_reg       <= RESP;
                    end else if (cnt_reg == CNT_LAST) begin
                        resp_result_reg <= QNAN;
                        resp_inv_op_reg <= 1'b0;
                        resp_err_reg    <= 1'b1;
                        mult_reset_reg  <= 1'b0;
                        resp_valid_reg  <= NUM_REQ'(1) << winner_reg;
                        state_reg       <= RESP;
                    end
                end

                RESP: begin
                    resp_valid_reg <= '0;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: behavioural multiplier stand-in plus a round-robin / latency
// reference model; directed scenarios followed by randomized traffic.
module tb_fmul_arbiter;

    localparam int P  = 32;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam logic [31:0] QNAN32 = 32'h7FC00000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mult_reset;
    logic [P-1:0]  mult_a;
    logic [P-1:0]  mult_b;
    logic [1:0]    mult_rounding;
    logic [P-1:0]  mult_result;
    logic          mult_done;
    logic          mult_inv_op;
    logic          hang = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = N - 1;

    fmul_arbiter_if #(.precision(P), .NUM_REQ(N)) bus ();

    fmul_arbiter #(.precision(P), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .mult_reset    (mult_reset),
        .mult_a        (mult_a),
        .mult_b        (mult_b),
        .mult_rounding (mult_rounding),
        .mult_result   (mult_result),
        .mult_done     (mult_done),
        .mult_inv_op   (mult_inv_op)
    );

    always #5 clk = ~clk;

    // Exact conversions for small non-negative integers (< 2^24).
    function automatic logic [31:0] fp_of_int(input int unsigned v);
        int p;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 32; i++) if (v[i]) p = i;
        m = v << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int unsigned int_of_fp(input logic [31:0] f);
        int p;
        int unsigned mant;
        if (f[30:23] == 8'h00) return 0;
        p = int'(f[30:23]) - 127;
        mant = {8'd0, 1'b1, f[22:0]};
        return mant >> (23 - p);
    endfunction

    // {inv_op, result} of the stand-in multiplier.
    function automatic logic [32:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic a_inf, b_inf, a_zero, b_zero, a_nan, b_nan;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:0] == 0);
        b_zero = (b[30:0] == 0);
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {1'b1, QNAN32};
        if (a_nan || b_nan) return {1'b0, QNAN32};
        if (a_inf || b_inf) return {1'b0, a[31] ^ b[31], 8'hFF, 23'h0};
        return {1'b0, fp_of_int(int_of_fp(a) * int_of_fp(b))};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    endfunction

    // Multiplier stand-in: done rises 4 cycles after reset release (2 for specials).
    int mcnt;
    always @(posedge clk) begin
        if (!mult_reset) begin
            mcnt        <= 0;
            mult_done   <= 1'b0;
            mult_result <= '0;
            mult_inv_op <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (!hang && (mcnt + 1 == (is_special(mult_a, mult_b) ? 2 : 4))) begin
                mult_done   <= 1'b1;
                {mult_inv_op, mult_result} <= model_mul(mult_a, mult_b);
            end
        end
    end

    // Reference arbitration: first requesting index after ptr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] r);
        bus.req_a[i*P +: P]      = a;
        bus.req_b[i*P +: P]      = b;
        bus.req_rounding[2*i +: 2] = r;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.grant, bus.resp_valid, bus.busy, mult_reset, bus.resp_inv_op, bus.resp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: grant=%b resp_valid=%b busy=%b mult_reset=%b inv=%b err=%b, required all 0",
                     bus.grant, bus.resp_valid, bus.busy, mult_reset, bus.resp_inv_op, bus.resp_err);
        end
        n_checks++;
        if ({mult_a, mult_b, mult_rounding, bus.resp_result} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: mult_a=%h mult_b=%h rnd=%b result=%h, required 0",
                     mult_a, mult_b, mult_rounding, bus.resp_result);
        end
        bus.req = 4'hF;
        #1;
        n_checks++;
        if (bus.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_grant: grant=%b, required 0000 while in reset", bus.grant);
        end
        bus.req = '0;
        @(negedge clk);
        reset = 1'b1;
        model_ptr = N - 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat;
        drive_req(0, 32'h40000000, 32'h40400000, 2'b10);
        bus.req = 4'b0001;
        #1;
        n_checks++;
        if (bus.grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b, required 0001", bus.grant);
        end
        model_ptr = 0;
        @(negedge clk);
        bus.req = '0;
        n_checks++;
        if (mult_a !== 32'h40000000 || mult_b !== 32'h40400000 || mult_rounding !== 2'b10
            || mult_reset !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_run: a=%h b=%h rnd=%b mreset=%b busy=%b, required 40000000 40400000 10 1 1",
                     mult_a, mult_b, mult_rounding, mult_reset, bus.busy);
        end
        lat = 1;
        while (bus.resp_valid === '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 6 || bus.resp_valid !== 4'b0001 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: lat=%0d resp_valid=%b busy=%b, required 6 0001 1",
                     lat, bus.resp_valid, bus.busy);
        end
        n_checks++;
        if (bus.resp_result !== 32'h40C00000 || bus.resp_inv_op !== 1'b0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: result=%h inv=%b err=%b, required 40c00000 0 0",
                     bus.resp_result, bus.resp_inv_op, bus.resp_err);
        end
        $display("op single: req=0 2.0*3.0 result=%h latency=%0d", bus.resp_result, lat);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int owner_q[$];
        int g_n, r_n, w, o;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_ptr = N - 1;
        for (int i = 0; i < N; i++) drive_req(i, fp_of_int(i + 2), fp_of_int(i + 3), 2'b00);
        bus.req = 4'hF;
        g_n = 0;
        r_n = 0;
        for (int cyc = 0; cyc < 80 && r_n < 5; cyc++) begin
            #1;
            if (bus.grant !== '0) begin
                w = rr_pick(4'hF, model_ptr);
                n_checks++;
                if (g_n >= 5 || bus.grant !== (4'b0001 << w) || w != exp_seq[g_n] || bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_grant: grant#%0d=%b busy=%b, required %b with busy 0",
                             g_n, bus.grant, bus.busy, 4'b0001 << w);
                end
                model_ptr = w;
                owner_q.push_back(w);
                g_n++;
            end
            if (bus.resp_valid !== '0) begin
                o = (owner_q.size() > 0) ? owner_q.pop_front() : 0;
                n_checks++;
                if (bus.resp_valid !== (4'b0001 << o)
                    || bus.resp_result !== fp_of_int((o + 2) * (o + 3))) begin
                    n_fail++;
                    $display("FAIL rr_resp: resp_valid=%b result=%h, required %b %h",
                             bus.resp_valid, bus.resp_result, 4'b0001 << o, fp_of_int((o + 2) * (o + 3)));
                end
                $display("op rr: owner=%0d result=%h", o, bus.resp_result);
                r_n++;
            end
            if (r_n == 5) bus.req = '0;
            @(negedge clk);
        end
        n_checks++;
        if (g_n != 5 || r_n != 5) begin
            n_fail++;
            $display("FAIL rr_count: grants=%0d responses=%0d, required 5 5", g_n, r_n);
        end
        bus.req = '0;
    endtask

    task automatic test_special();
        int lat;
        drive_req(2, 32'h7F800000, 32'h00000000, 2'b00);
        bus.req = 4'b0100;
        #1;
        n_checks++;
        if (bus.grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL special_grant: grant=%b, required 0100", bus.grant);
        end
        model_ptr = 2;
        @(negedge clk);
        bus.req = '0;
        lat = 1;
        while (bus.resp_valid === '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4 || bus.resp_valid !== 4'b0100 || bus.resp_result !== QNAN32
            || bus.resp_inv_op !== 1'b1 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL special_resp: lat=%0d rv=%b result=%h inv=%b err=%b, required 4 0100 7fc00000 1 0",
                     lat, bus.resp_valid, bus.resp_result, bus.resp_inv_op, bus.resp_err);
        end
        $display("op special: req=2 inf*0 result=%h inv=%b latency=%0d", bus.resp_result, bus.resp_inv_op, lat);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat;
        hang = 1'b1;
        drive_req(1, fp_of_int(5), fp_of_int(7), 2'b01);
        bus.req = 4'b0010;
        #1;
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL timeout_grant: grant=%b, required 0010", bus.grant);
        end
        model_ptr = 1;
        @(negedge clk);
        bus.req = '0;
        lat = 1;
        while (bus.resp_valid === '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != TO + 1 || bus.resp_valid !== 4'b0010 || mult_reset !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_timing: lat=%0d rv=%b mreset=%b busy=%b, required %0d 0010 0 1",
                     lat, bus.resp_valid, mult_reset, bus.busy, TO + 1);
        end
        n_checks++;
        if (bus.resp_result !== QNAN32 || bus.resp_err !== 1'b1 || bus.resp_inv_op !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_result: result=%h err=%b inv=%b, required 7fc00000 1 0",
                     bus.resp_result, bus.resp_err, bus.resp_inv_op);
        end
        $display("op timeout: req=1 result=%h err=%b latency=%0d", bus.resp_result, bus.resp_err, lat);
        @(negedge clk);
        hang = 1'b0;
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = '0;
        lat = 1;
        while (bus.resp_valid === '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 6 || bus.resp_valid !== 4'b0010 || bus.resp_result !== fp_of_int(35)
            || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recover: lat=%0d rv=%b result=%h err=%b, required 6 0010 %h 0",
                     lat, bus.resp_valid, bus.resp_result, bus.resp_err, fp_of_int(35));
        end
        $display("op after_timeout: req=1 result=%h latency=%0d", bus.resp_result, lat);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        drive_req(3, fp_of_int(9), fp_of_int(11), 2'b11);
        bus.req = 4'b1000;
        #1;
        n_checks++;
        if (bus.grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_grant: grant=%b, required 1000", bus.grant);
        end
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_ptr = N - 1;
        n_checks++;
        if ({bus.grant, bus.resp_valid, bus.busy, mult_reset, bus.resp_inv_op, bus.resp_err} !== '0
            || {mult_a, mult_b, mult_rounding, bus.resp_result} !== '0) begin
            n_fail++;
            $display("FAIL midrst_values: rv=%b busy=%b mreset=%b a=%h b=%h rnd=%b result=%h, required all 0",
                     bus.resp_valid, bus.busy, mult_reset, mult_a, mult_b, mult_rounding, bus.resp_result);
        end
        for (int i = 0; i < N; i++) drive_req(i, fp_of_int(i + 4), fp_of_int(2), 2'b00);
        bus.req = 4'hF;
        #1;
        n_checks++;
        if (bus.grant !== 4'b0001 || rr_pick(4'hF, model_ptr) != 0) begin
            n_fail++;
            $display("FAIL midrst_next_grant: grant=%b, required 0001", bus.grant);
        end
        model_ptr = 0;
        @(negedge clk);
        bus.req = '0;
        lat = 1;
        while (bus.resp_valid === '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 6 || bus.resp_valid !== 4'b0001 || bus.resp_result !== fp_of_int(8)) begin
            n_fail++;
            $display("FAIL midrst_resp: lat=%0d rv=%b result=%h, required 6 0001 %h",
                     lat, bus.resp_valid, bus.resp_result, fp_of_int(8));
        end
        $display("op after_reset: req=0 result=%h latency=%0d", bus.resp_result, lat);
        @(negedge clk);
    endtask

    // Random masks and operands every cycle; operands keep changing while RUN.
    task automatic test_random();
        int resp_in, idle_in, owner, w;
        int unsigned a_int[N];
        int unsigned b_int[N];
        logic [1:0] r_rnd[N];
        logic [N-1:0] mask, exp_grant, exp_rv;
        logic [31:0] lat_a, lat_b, exp_res;
        logic [1:0] lat_rnd;
        resp_in = -1;
        idle_in = 0;
        owner = 0;
        lat_a = '0;
        lat_b = '0;
        lat_rnd = '0;
        exp_res = '0;
        for (int c = 0; c < 400; c++) begin
            if (resp_in > 0) resp_in--;
            if (idle_in > 0) idle_in--;
            mask = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                a_int[i] = $urandom_range(1, 4095);
                b_int[i] = $urandom_range(1, 4095);
                r_rnd[i] = 2'($urandom_range(0, 3));
                drive_req(i, fp_of_int(a_int[i]), fp_of_int(b_int[i]), r_rnd[i]);
            end
            bus.req = mask;
            #1;
            exp_grant = '0;
            w = -1;
            if (idle_in == 0 && mask != '0) begin
                w = rr_pick(mask, model_ptr);
                exp_grant = 4'b0001 << w;
            end
            n_checks++;
            if (bus.grant !== exp_grant) begin
                n_fail++;
                $display("FAIL rand_grant: cycle=%0d req=%b grant=%b, required %b", c, mask, bus.grant, exp_grant);
            end
            if (idle_in >= 2 && idle_in <= 6) begin
                n_checks++;
                if (mult_a !== lat_a || mult_b !== lat_b || mult_rounding !== lat_rnd || mult_reset !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_hold: cycle=%0d a=%h b=%h rnd=%b mreset=%b, required %h %h %b 1",
                             c, mult_a, mult_b, mult_rounding, mult_reset, lat_a, lat_b, lat_rnd);
                end
            end
            exp_rv = (resp_in == 0) ? (4'b0001 << owner) : '0;
            n_checks++;
            if (bus.resp_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL rand_resp_valid: cycle=%0d rv=%b, required %b", c, bus.resp_valid, exp_rv);
            end
            if (resp_in == 0) begin
                n_checks++;
                if (bus.resp_result !== exp_res || bus.resp_inv_op !== 1'b0 || bus.resp_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_result: cycle=%0d result=%h inv=%b err=%b, required %h 0 0",
                             c, bus.resp_result, bus.resp_inv_op, bus.resp_err, exp_res);
                end
                $display("op random: owner=%0d result=%h expected=%h", owner, bus.resp_result, exp_res);
                resp_in = -1;
            end
            if (w >= 0) begin
                model_ptr = w;
                owner   = w;
                lat_a   = fp_of_int(a_int[w]);
                lat_b   = fp_of_int(b_int[w]);
                lat_rnd = r_rnd[w];
                exp_res = fp_of_int(a_int[w] * b_int[w]);
                resp_in = 6;
                idle_in = 7;
            end
            @(negedge clk);
        end
        bus.req = '0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        bus.req          = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.req_rounding = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_special();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before time 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
